// File: rtl/biquad_coeff_bank_pkg.sv
// Shared constants and types for the biquad coefficient bank: coefficient
// addresses, bank size, the unity coefficient and the commit state machine.
package biquad_coeff_bank_pkg;

    localparam int NUM_COEFFS = 5;

    localparam logic [2:0] ADDR_A0 = 3'd0;
    localparam logic [2:0] ADDR_A1 = 3'd1;
    localparam logic [2:0] ADDR_A2 = 3'd2;
    localparam logic [2:0] ADDR_B1 = 3'd3;
    localparam logic [2:0] ADDR_B2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_RAMP    = 2'd2
    } bank_state_t;

    // Unity gain in signed Q2.(bitsize-2).
    function automatic int coeff_unity(input int bitsize);
        return 1 << (bitsize - 2);
    endfunction

endpackage

// File: rtl/biquad_coeff_bank_if.sv
// Control-side register-write and commit port of the biquad coefficient bank.
// The master drives writes and commits; the slave (the bank) reports status.
interface biquad_coeff_bank_if #(
    parameter int BITSIZE = 16
) ();

    logic               wr_en;
    logic [2:0]         wr_addr;
    logic [BITSIZE-1:0] wr_data;
    logic               commit;
    logic               busy;
    logic               wr_err;
    logic               done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  busy, wr_err, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output busy, wr_err, done
    );

endinterface

// File: rtl/biquad_coeff_bank_slew.sv
// biquad_coeff_slew: one active coefficient register. With BIQUAD_COEFF_RAMP_EN
// it keeps a target and slews toward it by at most RAMP_STEP per frame.
module biquad_coeff_slew #(
    parameter int BITSIZE = 16
`ifdef BIQUAD_COEFF_RAMP_EN
  , parameter int RAMP_STEP = 64
`endif
) (
    input  logic               bclk,
    input  logic               rst,
    input  logic [BITSIZE-1:0] reset_val,
    input  logic [BITSIZE-1:0] shadow,
    input  logic               load,
`ifdef BIQUAD_COEFF_RAMP_EN
    input  logic               advance,
    output logic               settles,
`endif
    output logic [BITSIZE-1:0] active
);

`ifdef BIQUAD_COEFF_RAMP_EN
    localparam logic [BITSIZE:0]   STEP_W = (BITSIZE + 1)'(RAMP_STEP);
    localparam logic [BITSIZE-1:0] STEP_N = BITSIZE'(RAMP_STEP);

    logic [BITSIZE-1:0]        target;
    logic [BITSIZE-1:0]        goal;
    logic signed [BITSIZE:0]   diff;
    logic [BITSIZE:0]          mag;
    logic [BITSIZE-1:0]        stepped;

    // The apply edge takes its first step straight from the shadow value.
    always_comb begin
        goal    = load ? shadow : target;
        diff    = $signed({goal[BITSIZE-1], goal}) - $signed({active[BITSIZE-1], active});
        mag     = diff[BITSIZE] ? $unsigned(-diff) : $unsigned(diff);
        settles = (mag <= STEP_W);
        stepped = goal;
        if (!settles) begin
            stepped = diff[BITSIZE] ? (active - STEP_N) : (active + STEP_N);
        end
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            target <= reset_val;
            active <= reset_val;
        end else begin
            if (load) begin
                target <= shadow;
            end
            if (load || advance) begin
                active <= stepped;
            end
        end
    end
`else
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            active <= reset_val;
        end else if (load) begin
            active <= shadow;
        end
    end
`endif

endmodule

// File: rtl/biquad_coeff_bank.sv
// Biquad coefficient bank: shadow registers written over the control port,
// applied atomically on an lrclk rising edge. BIQUAD_COEFF_RAMP_EN adds slewing.
module biquad_coeff_bank
    import biquad_coeff_bank_pkg::*;
#(
    parameter int BITSIZE   = 16,
    parameter int RAMP_STEP = 64
) (
    input  logic                bclk,
    input  logic                rst,
    input  logic                lrclk,
    biquad_coeff_bank_if.slave  bus,
    output logic [BITSIZE-1:0]  a0,
    output logic [BITSIZE-1:0]  a1,
    output logic [BITSIZE-1:0]  a2,
    output logic [BITSIZE-1:0]  b1,
    output logic [BITSIZE-1:0]  b2
);

    localparam logic [BITSIZE-1:0] UNITY = BITSIZE'(coeff_unity(BITSIZE));

    if (RAMP_STEP < 1 || RAMP_STEP >= (1 << (BITSIZE - 1))) begin : g_bad_ramp_step
        $error("biquad_coeff_bank: RAMP_STEP out of range");
    end

    function automatic logic [BITSIZE-1:0] coeff_reset(input int idx);
        return (idx == int'(ADDR_A0)) ? UNITY : '0;
    endfunction

    bank_state_t        state, state_nxt;
    logic               lrclk_q;
    logic               frame_edge;
    logic               wr_accept;
    logic               load;
    logic               done_q, done_nxt;
    logic               wr_err_q, wr_err_nxt;
    logic [BITSIZE-1:0] shadow [NUM_COEFFS];
    logic [BITSIZE-1:0] active [NUM_COEFFS];
`ifdef BIQUAD_COEFF_RAMP_EN
    logic                  advance;
    logic [NUM_COEFFS-1:0] settles;
`endif

    assign frame_edge = lrclk & ~lrclk_q;
    assign wr_accept  = bus.wr_en && (state == ST_IDLE) && (bus.wr_addr <= ADDR_B2);
    assign wr_err_nxt = bus.wr_en && !wr_accept;

    // NOTE: the shadow set is a register file that must come out of reset
    // holding the passthrough set, so every entry is reset explicitly.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                shadow[i] <= coeff_reset(i);
            end
        end else begin
            for (int i = 0; i < NUM_COEFFS; i++) begin
                if (wr_accept && bus.wr_addr == 3'(i)) begin
                    shadow[i] <= bus.wr_data;
                end
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lrclk_q  <= 1'b1;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            lrclk_q  <= lrclk;
            done_q   <= done_nxt;
            wr_err_q <= wr_err_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done_nxt  = 1'b0;
`ifdef BIQUAD_COEFF_RAMP_EN
        advance   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A commit on a frame-edge cycle only registers; it applies next frame.
                if (bus.commit) begin
                    state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_edge) begin
                    load = 1'b1;
`ifdef BIQUAD_COEFF_RAMP_EN
                    if (&settles) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RAMP;
                    end
`else
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef BIQUAD_COEFF_RAMP_EN
            ST_RAMP: begin
                if (frame_edge) begin
                    advance = 1'b1;
                    if (&settles) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_COEFFS; i++) begin : g_coeff
        biquad_coeff_slew #(
            .BITSIZE   (BITSIZE)
`ifdef BIQUAD_COEFF_RAMP_EN
          , .RAMP_STEP (RAMP_STEP)
`endif
        ) u_slew (
            .bclk      (bclk),
            .rst       (rst),
            .reset_val (coeff_reset(i)),
            .shadow    (shadow[i]),
            .load      (load),
`ifdef BIQUAD_COEFF_RAMP_EN
            .advance   (advance),
            .settles   (settles[i]),
`endif
            .active    (active[i])
        );
    end

    assign a0 = active[ADDR_A0];
    assign a1 = active[ADDR_A1];
    assign a2 = active[ADDR_A2];
    assign b1 = active[ADDR_B1];
    assign b2 = active[ADDR_B2];

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_biquad_coeff_bank.sv
// Directed bench for biquad_coeff_bank: reset, apply, commit-on-edge, dropped
// writes, reset while pending, and slewing when BIQUAD_COEFF_RAMP_EN is defined.
module tb_biquad_coeff_bank;
    import biquad_coeff_bank_pkg::*;

    localparam int BITSIZE = 16;
    localparam logic [79:0] RESET_SET = {16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    logic bclk = 1'b0;
    logic rst;
    logic lrclk;
    logic [BITSIZE-1:0] a0, a1, a2, b1, b2;
    logic [79:0] coeffs;

    int assertions = 0;
    int failures   = 0;

    always #5 bclk = ~bclk;

    biquad_coeff_bank_if #(.BITSIZE(BITSIZE)) bus ();

    biquad_coeff_bank #(.BITSIZE(BITSIZE), .RAMP_STEP(64)) dut (
        .bclk  (bclk),
        .rst   (rst),
        .lrclk (lrclk),
        .bus   (bus),
        .a0    (a0),
        .a1    (a1),
        .a2    (a2),
        .b1    (b1),
        .b2    (b2)
    );

    assign coeffs = {a0, a1, a2, b1, b2};

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    // Leaves lrclk high with the registers updated by the edge cycle visible.
    task automatic frame();
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic saw_done;
        rst         = 1'b1;
        lrclk       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        assertions++;
        if (coeffs !== RESET_SET) begin
            failures++;
            $display("FAIL reset_coeffs: got %h expected %h", coeffs, RESET_SET);
        end
        assertions++;
        if ({bus.busy, bus.done, bus.wr_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: got busy/done/err=%b expected 000", {bus.busy, bus.done, bus.wr_err});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_done |= bus.done;
        end
        assertions++;
        if (saw_done !== 1'b0 || coeffs !== RESET_SET) begin
            failures++;
            $display("FAIL reset_no_false_edge: got done=%b coeffs=%h expected done=0 coeffs=%h", saw_done, coeffs, RESET_SET);
        end
    endtask

    task automatic test_apply();
        logic [79:0] exp_set;
        exp_set = {16'h4000, 16'h1234, 16'h0000, 16'h0000, 16'hF000};
        write_reg(ADDR_A1, 16'h1234);
        assertions++;
        if (bus.wr_err !== 1'b0) begin
            failures++;
            $display("FAIL apply_write_ok: got wr_err=%b expected 0", bus.wr_err);
        end
        write_reg(ADDR_B2, 16'hF000);
        do_commit();
        assertions++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL apply_busy_pending: got %b expected 1", bus.busy);
        end
        lrclk = 1'b0;
        tick();
        lrclk = 1'b1;
        assertions++;
        if (coeffs !== RESET_SET) begin
            failures++;
            $display("FAIL apply_before_edge: got %h expected %h", coeffs, RESET_SET);
        end
        tick();
        assertions++;
        if (coeffs !== exp_set || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL apply_after_edge: got %h done=%b busy=%b expected %h done=1 busy=0", coeffs, bus.done, bus.busy, exp_set);
        end
        tick();
        assertions++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL apply_done_single: got done=%b expected 0", bus.done);
        end
    endtask

    task automatic test_commit_on_edge();
        logic [79:0] old_set, exp_set;
        old_set = {16'h4000, 16'h1234, 16'h0000, 16'h0000, 16'hF000};
        exp_set = {16'h4000, 16'h1234, 16'h0555, 16'h0000, 16'hF000};
        lrclk = 1'b0;
        tick();
        write_reg(ADDR_A2, 16'h0555);
        lrclk      = 1'b1;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        assertions++;
        if (coeffs !== old_set || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL edge_commit_same_cycle: got %h done=%b busy=%b expected %h done=0 busy=1", coeffs, bus.done, bus.busy, old_set);
        end
        repeat (4) tick();
        assertions++;
        if (coeffs !== old_set || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL edge_commit_hold: got %h busy=%b expected %h busy=1", coeffs, bus.busy, old_set);
        end
        frame();
        assertions++;
        if (coeffs !== exp_set || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL edge_commit_next_frame: got %h done=%b expected %h done=1", coeffs, bus.done, exp_set);
        end
    endtask

    task automatic test_write_errors();
        logic [79:0] exp_set;
        exp_set = {16'h4000, 16'h1234, 16'h0555, 16'h0000, 16'hF000};
        do_commit();
        do_commit();
        assertions++;
        if (bus.wr_err !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL err_commit_while_busy: got wr_err=%b busy=%b expected 0 1", bus.wr_err, bus.busy);
        end
        write_reg(ADDR_A0, 16'h0001);
        assertions++;
        if (bus.wr_err !== 1'b1) begin
            failures++;
            $display("FAIL err_write_busy: got wr_err=%b expected 1", bus.wr_err);
        end
        tick();
        assertions++;
        if (bus.wr_err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width: got wr_err=%b expected 0", bus.wr_err);
        end
        frame();
        assertions++;
        if (coeffs !== exp_set || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL err_frozen_shadow: got %h done=%b expected %h done=1", coeffs, bus.done, exp_set);
        end
        write_reg(3'd6, 16'hABCD);
        assertions++;
        if (bus.wr_err !== 1'b1 || bus.busy !== 1'b0 || coeffs !== exp_set) begin
            failures++;
            $display("FAIL err_bad_addr: got wr_err=%b busy=%b coeffs=%h expected 1 0 %h", bus.wr_err, bus.busy, coeffs, exp_set);
        end
        do_commit();
        frame();
        assertions++;
        if (coeffs !== exp_set || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL err_shadow_unchanged: got %h done=%b expected %h done=1", coeffs, bus.done, exp_set);
        end
    endtask

    task automatic test_reset_pending();
        write_reg(ADDR_A1, 16'h7777);
        do_commit();
        assertions++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL rstp_busy: got %b expected 1", bus.busy);
        end
        rst = 1'b1;
        #2;
        assertions++;
        if (coeffs !== RESET_SET || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rstp_async: got %h busy=%b expected %h busy=0", coeffs, bus.busy, RESET_SET);
        end
        tick();
        rst = 1'b0;
        frame();
        assertions++;
        if (coeffs !== RESET_SET || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rstp_commit_lost: got %h done=%b busy=%b expected %h 0 0", coeffs, bus.done, bus.busy, RESET_SET);
        end
        do_commit();
        frame();
        assertions++;
        if (coeffs !== RESET_SET || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL rstp_shadow_reset: got %h done=%b expected %h done=1", coeffs, bus.done, RESET_SET);
        end
    endtask

`ifdef BIQUAD_COEFF_RAMP_EN
    task automatic test_ramp();
        logic [15:0] exp_a0;
        logic signed [15:0] prev;
        logic got_done;
        write_reg(ADDR_A0, 16'h4100);
        do_commit();
        for (int k = 1; k <= 4; k++) begin
            frame();
            exp_a0 = 16'h4000 + 16'(64 * k);
            assertions++;
            if (a0 !== exp_a0 || bus.done !== (k == 4) || bus.busy !== (k != 4)) begin
                failures++;
                $display("FAIL ramp_step%0d: got a0=%h done=%b busy=%b expected %h %b %b", k, a0, bus.done, bus.busy, exp_a0, k == 4, k != 4);
            end
        end
        write_reg(ADDR_A1, 16'h8000);
        do_commit();
        got_done = 1'b0;
        for (int f = 0; f < 600 && !got_done; f++) begin
            frame();
            got_done = bus.done;
        end
        assertions++;
        if (!got_done || a1 !== 16'h8000) begin
            failures++;
            $display("FAIL ramp_to_min: got done=%b a1=%h expected 1 8000", got_done, a1);
        end
        write_reg(ADDR_A1, 16'h7FFF);
        do_commit();
        got_done = 1'b0;
        prev     = $signed(a1);
        for (int f = 0; f < 1100 && !got_done; f++) begin
            frame();
            got_done = bus.done;
            assertions++;
            if (!($signed(a1) > prev)) begin
                failures++;
                $display("FAIL ramp_monotonic: frame %0d got a1=%h after %h", f, a1, prev);
            end
            prev = $signed(a1);
        end
        assertions++;
        if (!got_done || a1 !== 16'h7FFF) begin
            failures++;
            $display("FAIL ramp_to_max: got done=%b a1=%h expected 1 7fff", got_done, a1);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_apply();
        test_commit_on_edge();
        test_write_errors();
        test_reset_pending();
`ifdef BIQUAD_COEFF_RAMP_EN
        test_ramp();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_bank.md
Name: biquad_coeff_bank

Overview:
Coefficient writer that drives the a0/a1/a2/b1/b2 inputs of the biquad filter from a simple register-write port. Control logic writes new coefficients into shadow registers and requests a commit. The block switches the active set atomically on an lrclk rising edge, so the filter never runs a frame with a mixed coefficient set. It sits between the control/CSR logic and each biquad instance, in the bclk domain.

Parameters:
BITSIZE, 16, coefficient width; signed Q2.(BITSIZE-2), matching the biquad multiplier shift.
RAMP_STEP, 64, maximum change per frame per coefficient; used only with the optional feature.

Ports:
bclk  input  1  system/bit clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
lrclk  input  1  frame clock, synchronous to bclk; rising edge marks the frame boundary.
wr_en  input  1  write strobe for one cycle.
wr_addr  input  3  0=a0, 1=a1, 2=a2, 3=b1, 4=b2; 5..7 invalid.
wr_data  input  BITSIZE  signed coefficient value.
commit  input  1  single-cycle request to apply the shadow set.
busy  output  1  commit pending (or ramp in progress).
wr_err  output  1  1-cycle pulse when a write is dropped.
done  output  1  1-cycle pulse when the active set equals the committed set.
a0, a1, a2, b1, b2  output  BITSIZE each  active coefficients, registered.

Behaviour:
- Reset (asynchronous, active-high) is identical for the shadow and active sets: a0 = 2^(BITSIZE-2) (unity; 16'h4000 at 16 bits), a1 = a2 = b1 = b2 = 0, which gives a passthrough filter. busy=0, wr_err=0, done=0, lrclk_q=1.
- Frame edge: frame_edge = lrclk & ~lrclk_q, with lrclk_q a register. The reset value lrclk_q=1 prevents a false edge when lrclk is high as reset releases.
- State machine states:
  - IDLE: busy=0.
  - PENDING: busy=1.
  - RAMP: busy=1; exists only with the optional feature.
- Writes:
  - In IDLE, wr_en with addr 0..4 updates that shadow register on the next edge. Active outputs do not change.
  - wr_en with addr 5..7 is dropped and pulses wr_err.
  - wr_en while busy is dropped and pulses wr_err; the shadow set stays frozen.
- Commit:
  - commit in IDLE sets PENDING on the next edge.
  - commit while busy is ignored, with no error.
  - wr_en and commit in the same IDLE cycle: the write lands, and the commit captures the updated shadow set.
- Apply: in PENDING, on a cycle with frame_edge, the active set is loaded from shadow, the state returns to IDLE and done pulses. Outputs change one bclk after the frame-edge cycle.
- Commit and frame edge in the same cycle: the commit is registered only. It applies on the following frame edge, never the current one.
- Reset mid-PENDING/RAMP: returns to the reset values; the pending commit is lost.
- No arithmetic on the apply path; it is a pure register copy.

Optional Feature:
Macro: BIQUAD_COEFF_RAMP_EN.
- Defined:
  - Apply moves to RAMP instead of copying.
  - On each frame edge, every active coefficient moves toward its target by min(|target-active|, RAMP_STEP).
  - The difference is computed in BITSIZE+1 signed bits, so there is no wrap at the ±full-scale extremes.
  - When all five coefficients equal their targets, the state returns to IDLE and done pulses on that edge's update cycle.
  - If the first-edge difference is ≤ RAMP_STEP, the behaviour matches an immediate copy.
- Undefined: immediate copy as above; the RAMP state and RAMP_STEP logic are absent.

Decomposition:
- Shared package: coefficient address constants (ADDR_A0..ADDR_B2), number of coefficients (5), the unity constant 2^(BITSIZE-2), and the state enum (IDLE/PENDING/RAMP).
- One sub-module is natural: biquad_coeff_slew, a per-coefficient register holding active, target and step logic, instantiated 5×. In the non-ramp build it reduces to a load-enable register.

Test Plan:
- Reset with lrclk held high, then release -> a0=16'h4000, others 0, busy=0, no done pulse until a commit.
- Write a1=16'h1234 and b2=16'hF000, commit, then lrclk rising -> outputs unchanged before the edge; one cycle after the edge a1=16'h1234, b2=16'hF000; done pulses once; busy drops.
- Commit asserted on the same cycle as an lrclk rising edge -> no change on that edge; apply on the next rising edge.
- While busy, write a0=16'h0001, and separately write any value to addr 6 in IDLE -> wr_err pulses each time; shadow a0 and all actives unaffected.
- Assert rst while PENDING -> immediate return to reset values; a later lrclk edge causes no update and no done pulse.
- (BIQUAD_COEFF_RAMP_EN, RAMP_STEP=64) commit a0=16'h4100 from 16'h4000 -> a0 reads 0x4040, 0x4080, 0x40C0, 0x4100 on successive frames; done on the 4th; busy high throughout. Also 16'h8000→16'h7FFF: no wrap, monotonic increase.
